// File: rtl/adc_echo_accum_if.sv
// Bus bundle for adc_echo_accum: configuration/start, ADC sample stream,
// output word handshake and status flags.
// master: the controller/consumer side; slave: the accumulator itself.
interface adc_echo_accum_if #(
    parameter int ADC_WIDTH  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  START;
    logic [15:0]           NUM_ECHOES;
    logic [ADDR_WIDTH:0]   SAMPLES_PER_ECHO;
    logic                  ACQ_EN;
    logic [ADC_WIDTH-1:0]  ADC_DATA;
    logic [ACC_WIDTH-1:0]  DOUT;
    logic                  DOUT_VALID;
    logic                  DOUT_READY;
    logic                  DOUT_LAST;
    logic                  BUSY;
    logic                  DONE;
    logic                  LEN_ERR;

    modport master (
        output START, NUM_ECHOES, SAMPLES_PER_ECHO, ACQ_EN, ADC_DATA, DOUT_READY,
        input  DOUT, DOUT_VALID, DOUT_LAST, BUSY, DONE, LEN_ERR
    );

    modport slave (
        input  START, NUM_ECHOES, SAMPLES_PER_ECHO, ACQ_EN, ADC_DATA, DOUT_READY,
        output DOUT, DOUT_VALID, DOUT_LAST, BUSY, DONE, LEN_ERR
    );
endinterface

// File: rtl/adc_echo_accum.sv
// adc_echo_accum: coherent echo accumulator. Each acquisition window
// (ACQ_EN high) delivers one echo; sample i of every echo is summed into
// buffer word i, and after the last echo the buffer is streamed out over a
// valid/ready handshake.
// Optional build macro: ADC_ECHO_ACCUM_SIGNED_EN -- treat ADC_DATA as two's
// complement (sign-extend); undefined means unsigned (zero-extend).
module adc_echo_accum #(
    parameter int ADC_WIDTH  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    adc_echo_accum_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_SPE = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ARM   = 6'b000010,
        S_ACC   = 6'b000100,
        S_GAP   = 6'b001000,
        S_DRAIN = 6'b010000,
        S_FIN   = 6'b100000
    } state_t;

    function automatic logic [ACC_WIDTH-1:0] ext_sample(input logic [ADC_WIDTH-1:0] s);
`ifdef ADC_ECHO_ACCUM_SIGNED_EN
        return {{(ACC_WIDTH-ADC_WIDTH){s[ADC_WIDTH-1]}}, s};
`else
        return {{(ACC_WIDTH-ADC_WIDTH){1'b0}}, s};
`endif
    endfunction

    // Control state
    state_t              state_q;
    logic [15:0]         num_q;
    logic [ADDR_WIDTH:0] spe_q;
    logic [15:0]         echo_q;
    logic [ADDR_WIDTH:0] idx_q;
    logic [ADDR_WIDTH:0] rd_idx_q;
    logic                acq_prev_q;
    logic                len_err_q;
    logic                busy_q;
    logic                done_q;
    logic                dout_valid_q;
    logic                dout_last_q;

    // Read-modify-write pipeline (stage 1 holds the sample being written)
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_idx_q;
    logic                  wr_first_q;
    logic [ADC_WIDTH-1:0]  wr_samp_q;

    // Accumulation buffer and its single registered read port
    logic [ACC_WIDTH-1:0]  mem [DEPTH];
    logic [ACC_WIDTH-1:0]  rd_data_q;

    logic                  acq_rise;
    logic                  start_take;
    logic                  acc_take;
    logic                  drain_load;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ACC_WIDTH-1:0]  wr_data;
    logic [15:0]           echo_nxt;

    // Sample acceptance, read-port arbitration and the accumulate adder
    always_comb begin
        acq_rise   = bus.ACQ_EN && !acq_prev_q;
        start_take = ((state_q == S_ARM) || (state_q == S_GAP)) && acq_rise;
        acc_take   = (state_q == S_ACC) && bus.ACQ_EN && (idx_q < spe_q);
        drain_load = (state_q == S_DRAIN) && (rd_idx_q < spe_q) &&
                     (!dout_valid_q || bus.DOUT_READY);
        rd_en      = start_take || acc_take || drain_load;
        rd_addr    = '0;
        if (acc_take) begin
            rd_addr = idx_q[ADDR_WIDTH-1:0];
        end else if (drain_load) begin
            rd_addr = rd_idx_q[ADDR_WIDTH-1:0];
        end
        echo_nxt   = echo_q + 16'd1;
        // Echo 0 overwrites, so stale buffer contents never leak into a new job
        wr_data    = (wr_first_q ? '0 : rd_data_q) + ext_sample(wr_samp_q);
    end

    // Buffer: stage-1 write and one read per cycle; consecutive samples hit
    // distinct words, so the read of sample i+1 never collides with write i
    always_ff @(posedge CLK) begin
        if (wr_en_q) begin
            mem[wr_idx_q] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Stage 0 -> stage 1 write-enable (control, reset)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= start_take || acc_take;
        end
    end

    // Stage 0 -> stage 1 sample/address capture (data, no reset)
    always_ff @(posedge CLK) begin
        if (start_take || acc_take) begin
            wr_idx_q   <= start_take ? '0 : idx_q[ADDR_WIDTH-1:0];
            wr_first_q <= (echo_q == 16'd0);
            wr_samp_q  <= bus.ADC_DATA;
        end
    end

    // Main FSM with registered status/handshake outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            spe_q        <= '0;
            echo_q       <= '0;
            idx_q        <= '0;
            rd_idx_q     <= '0;
            acq_prev_q   <= 1'b0;
            len_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            acq_prev_q <= bus.ACQ_EN;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        num_q    <= (bus.NUM_ECHOES == 16'd0) ? 16'd1 : bus.NUM_ECHOES;
                        spe_q    <= bus.SAMPLES_PER_ECHO;
                        echo_q   <= '0;
                        idx_q    <= '0;
                        rd_idx_q <= '0;
                        busy_q   <= 1'b1;
                        if ((bus.SAMPLES_PER_ECHO == '0) || (bus.SAMPLES_PER_ECHO > MAX_SPE)) begin
                            len_err_q <= 1'b1;
                            state_q   <= S_FIN;
                        end else begin
                            len_err_q <= 1'b0;
                            state_q   <= S_ARM;
                        end
                    end
                end
                S_ARM, S_GAP: begin
                    // Only a fresh rising edge starts an echo; sample 0 is taken now
                    if (acq_rise) begin
                        idx_q   <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (bus.ACQ_EN) begin
                        if (acc_take) begin
                            idx_q <= idx_q + 1'b1;
                        end else begin
                            len_err_q <= 1'b1;
                        end
                    end else begin
                        if (idx_q != spe_q) begin
                            len_err_q <= 1'b1;
                        end
                        echo_q  <= echo_nxt;
                        idx_q   <= '0;
                        state_q <= (echo_nxt >= num_q) ? S_DRAIN : S_GAP;
                    end
                end
                S_DRAIN: begin
                    if (drain_load) begin
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= (rd_idx_q == spe_q - 1'b1);
                        rd_idx_q     <= rd_idx_q + 1'b1;
                    end else if (bus.DOUT_READY) begin
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                    end
                    if (dout_valid_q && bus.DOUT_READY && dout_last_q) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The read register only advances on an accepted word, so DOUT holds while stalled
    assign bus.DOUT       = dout_valid_q ? rd_data_q : '0;
    assign bus.DOUT_VALID = dout_valid_q;
    assign bus.DOUT_LAST  = dout_last_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.LEN_ERR    = len_err_q;

endmodule
